// File: rtl/ysyx_22050612_dmem_responder.sv
// Data-memory responder: accepts one 64-bit read or byte-masked write at a time,
// services it from an internal doubleword SRAM after LATENCY cycles and returns
// the result over a response handshake.
//
// Handshake rule (both channels): a transfer happens on a rising clk edge where
// valid and ready are both high. req_ready and resp_valid come from registered
// state only, never from req_valid or resp_ready. Once resp_valid rises,
// resp_rdata and resp_err stay fixed until the response transfer.
module ysyx_22050612_dmem_responder #(
  parameter int          DEPTH_LOG2 = 10,
  parameter logic [63:0] BASE       = 64'h8000_0000,
  parameter int          LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [7:0]  req_wmask,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [63:0] resp_rdata,
  output logic        resp_err,
  output logic [1:0]  dbg_state
);

  localparam int         DEPTH    = 1 << DEPTH_LOG2;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        enter_resp;
  logic        req_fire;

  logic        lat_wen_q;
  logic [63:0] lat_addr_q;
  logic [63:0] lat_wdata_q;
  logic [7:0]  lat_wmask_q;

  logic                  acc_wen;
  logic [63:0]           acc_addr;
  logic [63:0]           acc_wdata;
  logic [7:0]            acc_wmask;
  logic [63:0]           acc_off;
  logic [63:0]           acc_word;
  logic [DEPTH_LOG2-1:0] acc_idx;
  logic                  acc_in_range;

  logic [63:0] mem [DEPTH];

  assign req_ready  = (state_q == S_IDLE) && !rst;
  assign resp_valid = (state_q == S_RESP);
  assign req_fire   = req_valid && req_ready;
  assign dbg_state  = state_q;

  // Next-state logic: count down the latency, enter RESP when it expires.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          cnt_d = CNT_INIT;
          if (LATENCY == 1) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end
      end
      S_RESP: begin
        if (resp_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and latency counter; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Capture the request at the acceptance edge only.
  always_ff @(posedge clk) begin
    if (req_fire) begin
      lat_wen_q   <= req_wen;
      lat_addr_q  <= req_addr;
      lat_wdata_q <= req_wdata;
      lat_wmask_q <= req_wmask;
    end
  end

  // With LATENCY 1 the access happens on the acceptance edge itself, so the
  // live request is used; otherwise the captured copy is used.
  always_comb begin
    if (LATENCY == 1) begin
      acc_wen   = req_wen;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_wmask = req_wmask;
    end else begin
      acc_wen   = lat_wen_q;
      acc_addr  = lat_addr_q;
      acc_wdata = lat_wdata_q;
      acc_wmask = lat_wmask_q;
    end
  end

  // Address decode without wrap: offset below BASE or past the array is an error.
  always_comb begin
    acc_off      = acc_addr - BASE;
    acc_word     = acc_off >> 3;
    acc_idx      = acc_word[DEPTH_LOG2-1:0];
    acc_in_range = (acc_addr >= BASE) && ((acc_word >> DEPTH_LOG2) == 64'd0);
  end

  // Byte-masked write on the edge entering RESP; memory is never reset.
  always_ff @(posedge clk) begin
    if (!rst && enter_resp && acc_wen && acc_in_range) begin
      for (int b = 0; b < 8; b++) begin
        if (acc_wmask[b]) mem[acc_idx][8*b +: 8] <= acc_wdata[8*b +: 8];
      end
    end
  end

  // Response payload: loaded on entering RESP, held until the response transfer.
  always_ff @(posedge clk) begin
    if (rst) begin
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end else if (enter_resp) begin
      resp_err   <= !acc_in_range;
      resp_rdata <= (!acc_wen && acc_in_range) ? mem[acc_idx] : 64'd0;
    end else if (state_q == S_RESP && resp_ready) begin
      resp_rdata <= 64'd0;
      resp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ysyx_22050612_dmem_responder.sv
// Bench for the data-memory responder: four instances at LATENCY 2, 3, 1 and 15,
// each driven by scenario tasks and checked against a word-array memory model.
module tb_ysyx_22050612_dmem_responder;

  localparam int          NI   = 4;
  localparam logic [63:0] BASE = 64'h8000_0000;
  localparam logic [63:0] RB   = 64'h8000_0100;

  function automatic int lat_of(int k);
    case (k)
      0:       return 2;
      1:       return 3;
      2:       return 1;
      default: return 15;
    endcase
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        rst        [NI];
  logic        req_valid  [NI];
  logic        req_ready  [NI];
  logic        req_wen    [NI];
  logic [63:0] req_addr   [NI];
  logic [63:0] req_wdata  [NI];
  logic [7:0]  req_wmask  [NI];
  logic        resp_valid [NI];
  logic        resp_ready [NI];
  logic [63:0] resp_rdata [NI];
  logic        resp_err   [NI];
  logic [1:0]  dbg_state  [NI];

  genvar g;
  generate
    for (g = 0; g < NI; g++) begin : g_dut
      ysyx_22050612_dmem_responder #(.LATENCY(lat_of(g))) u_dut (
        .clk        (clk),
        .rst        (rst[g]),
        .req_valid  (req_valid[g]),
        .req_ready  (req_ready[g]),
        .req_wen    (req_wen[g]),
        .req_addr   (req_addr[g]),
        .req_wdata  (req_wdata[g]),
        .req_wmask  (req_wmask[g]),
        .resp_valid (resp_valid[g]),
        .resp_ready (resp_ready[g]),
        .resp_rdata (resp_rdata[g]),
        .resp_err   (resp_err[g]),
        .dbg_state  (dbg_state[g])
      );
    end
  endgenerate

  int n_cmp = 0;
  int n_err = 0;

  // ---------------- reference model ----------------
  logic [63:0] mdl_mem [NI][1024];
  logic [63:0] e_rdata;
  logic        e_err;

  task automatic model_apply(input int k, input logic wen, input logic [63:0] addr,
                             input logic [63:0] wdata, input logic [7:0] wmask);
    int idx;
    if (addr < BASE || addr >= BASE + 64'd8192) begin
      e_err   = 1'b1;
      e_rdata = 64'd0;
    end else begin
      idx   = int'((addr - BASE) / 8);
      e_err = 1'b0;
      if (wen) begin
        for (int b = 0; b < 8; b++)
          if (wmask[b]) mdl_mem[k][idx][8*b +: 8] = wdata[8*b +: 8];
        e_rdata = 64'd0;
      end else begin
        e_rdata = mdl_mem[k][idx];
      end
    end
  endtask

  // ---------------- driver ----------------
  int          o_lat;
  logic [63:0] o_rdata;
  logic        o_err;
  bit          o_bp, o_post, o_rdy;

  // One transaction; during 'hold' stall cycles a second request is offered.
  task automatic do_txn(input int k, input logic wen, input logic [63:0] addr,
                        input logic [63:0] wdata, input logic [7:0] wmask, input int hold);
    o_lat = -1; o_rdata = 'x; o_err = 'x; o_bp = 1'b1; o_post = 1'b0;
    @(negedge clk);
    resp_ready[k] = 1'b0;
    o_rdy = (req_ready[k] === 1'b1);
    req_valid[k] = 1'b1; req_wen[k] = wen; req_addr[k] = addr;
    req_wdata[k] = wdata; req_wmask[k] = wmask;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    req_wen[k]   = 1'($urandom_range(0, 1));
    req_addr[k]  = {$urandom, $urandom};
    req_wdata[k] = {$urandom, $urandom};
    req_wmask[k] = 8'($urandom);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (resp_valid[k] === 1'b1) begin
        o_lat = c;
        break;
      end
      if (req_ready[k] !== 1'b0) o_bp = 1'b0;
    end
    if (o_lat < 0) return;
    o_rdata = resp_rdata[k];
    o_err   = resp_err[k];
    for (int h = 0; h < hold; h++) begin
      req_valid[k] = 1'b1;
      req_wen[k]   = 1'b1;
      @(posedge clk);
      @(negedge clk);
      if (resp_valid[k] !== 1'b1 || resp_rdata[k] !== o_rdata ||
          resp_err[k] !== o_err || req_ready[k] !== 1'b0) o_bp = 1'b0;
    end
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    o_post = (resp_valid[k] === 1'b0) && (req_ready[k] === 1'b1);
    resp_ready[k] = 1'b0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    @(negedge clk);
    for (int k = 0; k < NI; k++) rst[k] = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (req_ready[k] !== 1'b0 || resp_valid[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_during k=%0d req_ready=%b resp_valid=%b want 0 0", k, req_ready[k], resp_valid[k]);
      end
    end
    for (int k = 0; k < NI; k++) rst[k] = 1'b0;
    #1;
    for (int k = 0; k < NI; k++) begin
      n_cmp++;
      if (req_ready[k] !== 1'b1 || resp_valid[k] !== 1'b0 || resp_rdata[k] !== 64'd0 || resp_err[k] !== 1'b0) begin
        n_err++;
        $display("FAIL reset_after k=%0d req_ready=%b resp_valid=%b rdata=%h err=%b want 1 0 0 0",
                 k, req_ready[k], resp_valid[k], resp_rdata[k], resp_err[k]);
      end
    end
  endtask

  task automatic test_write_read(input int k);
    logic        wen  [3] = '{1'b1, 1'b0, 1'b0};
    logic [63:0] addr [3] = '{64'h8000_0010, 64'h8000_0010, 64'h8000_0017};
    for (int i = 0; i < 3; i++) begin
      model_apply(k, wen[i], addr[i], 64'h1122_3344_5566_7788, 8'hFF);
      do_txn(k, wen[i], addr[i], 64'h1122_3344_5566_7788, 8'hFF, 0);
      n_cmp++;
      if (o_lat !== lat_of(k) || o_rdata !== e_rdata || o_err !== e_err || !o_bp || !o_post || !o_rdy) begin
        n_err++;
        $display("FAIL write_read k=%0d i=%0d lat=%0d want %0d rdata=%h want %h err=%b want %b bp=%b post=%b rdy=%b",
                 k, i, o_lat, lat_of(k), o_rdata, e_rdata, o_err, e_err, o_bp, o_post, o_rdy);
      end
    end
  endtask

  task automatic test_byte_mask(input int k);
    logic        wen   [6] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] addr  [6] = '{64'h8000_0020, 64'h8000_0020, 64'h8000_0027,
                               64'h8000_0023, 64'h8000_0020, 64'h8000_0021};
    logic [63:0] wdata [6] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 64'd0,
                               64'hDEAD_BEEF_0BAD_F00D, 64'h0123_4567_89AB_CDEF, 64'd0};
    logic [7:0]  wmask [6] = '{8'hFF, 8'h0F, 8'h00, 8'h00, 8'hA5, 8'h00};
    for (int i = 0; i < 6; i++) begin
      model_apply(k, wen[i], addr[i], wdata[i], wmask[i]);
      do_txn(k, wen[i], addr[i], wdata[i], wmask[i], 0);
      n_cmp++;
      if (o_lat !== lat_of(k) || o_rdata !== e_rdata || o_err !== e_err || !o_post) begin
        n_err++;
        $display("FAIL byte_mask k=%0d i=%0d lat=%0d rdata=%h want %h err=%b want %b post=%b",
                 k, i, o_lat, o_rdata, e_rdata, o_err, e_err, o_post);
      end
    end
  endtask

  task automatic test_out_of_range(input int k);
    logic        wen  [5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    logic [63:0] addr [5] = '{64'h8000_0000, 64'h7FFF_FFF8, 64'h8000_2000,
                              64'hFFFF_FFFF_FFFF_FFF8, 64'h8000_0000};
    logic [63:0] wd;
    for (int i = 0; i < 5; i++) begin
      wd = {$urandom, $urandom};
      model_apply(k, wen[i], addr[i], wd, 8'hFF);
      do_txn(k, wen[i], addr[i], wd, 8'hFF, 0);
      n_cmp++;
      if (o_lat !== lat_of(k) || o_rdata !== e_rdata || o_err !== e_err || !o_post) begin
        n_err++;
        $display("FAIL out_of_range k=%0d i=%0d lat=%0d rdata=%h want %h err=%b want %b post=%b",
                 k, i, o_lat, o_rdata, e_rdata, o_err, e_err, o_post);
      end
    end
  endtask

  task automatic test_backpressure(input int k);
    logic [63:0] wd;
    wd = {$urandom, $urandom};
    for (int i = 0; i < 2; i++) begin
      model_apply(k, (i == 0), 64'h8000_0040, wd, 8'hFF);
      do_txn(k, (i == 0), 64'h8000_0040, wd, 8'hFF, 5);
      n_cmp++;
      if (o_lat !== lat_of(k) || o_rdata !== e_rdata || o_err !== e_err || !o_bp || !o_post) begin
        n_err++;
        $display("FAIL backpressure k=%0d i=%0d lat=%0d rdata=%h want %h err=%b stable=%b post=%b",
                 k, i, o_lat, o_rdata, e_rdata, o_err, o_bp, o_post);
      end
    end
  endtask

  task automatic test_random(input int k);
    logic        wen;
    logic [63:0] addr, wd;
    logic [7:0]  wm;
    int          hold;
    for (int i = 0; i < 8; i++) begin
      wd = {$urandom, $urandom};
      model_apply(k, 1'b1, RB + 64'(8 * i), wd, 8'hFF);
      do_txn(k, 1'b1, RB + 64'(8 * i), wd, 8'hFF, 0);
      n_cmp++;
      if (o_lat !== lat_of(k) || o_err !== 1'b0 || o_rdata !== 64'd0) begin
        n_err++;
        $display("FAIL random_fill k=%0d i=%0d lat=%0d err=%b rdata=%h want 0 0", k, i, o_lat, o_err, o_rdata);
      end
    end
    for (int i = 0; i < 20; i++) begin
      if ($urandom_range(0, 7) == 0)
        addr = ($urandom_range(0, 1) == 0) ? BASE - 64'(8 * (1 + $urandom_range(0, 3)))
                                           : BASE + 64'h2000 + 64'($urandom_range(0, 31));
      else
        addr = RB + 64'(8 * $urandom_range(0, 7)) + 64'($urandom_range(0, 7));
      wen  = 1'($urandom_range(0, 1));
      wd   = {$urandom, $urandom};
      wm   = 8'($urandom);
      hold = $urandom_range(0, 2);
      model_apply(k, wen, addr, wd, wm);
      do_txn(k, wen, addr, wd, wm, hold);
      n_cmp++;
      if (o_lat !== lat_of(k) || o_rdata !== e_rdata || o_err !== e_err || !o_bp || !o_post || !o_rdy) begin
        n_err++;
        $display("FAIL random k=%0d i=%0d addr=%h wen=%b lat=%0d rdata=%h want %h err=%b want %b bp=%b post=%b",
                 k, i, addr, wen, o_lat, o_rdata, e_rdata, o_err, e_err, o_bp, o_post);
      end
    end
  endtask

  task automatic test_back_to_back(input int k);
    logic [63:0] exp_q[$];
    logic [63:0] exp;
    int issued = 0, got = 0, last_acc = -1;
    @(negedge clk);
    resp_ready[k] = 1'b1;
    req_valid[k]  = 1'b1;
    req_wen[k]    = 1'b0;
    req_addr[k]   = RB;
    req_wmask[k]  = 8'hFF;
    for (int c = 0; c < 400 && got < 6; c++) begin
      if (resp_valid[k] === 1'b1) begin
        n_cmp++;
        if (exp_q.size() == 0) begin
          n_err++;
          $display("FAIL b2b_extra k=%0d rdata=%h with no outstanding read", k, resp_rdata[k]);
        end else begin
          exp = exp_q.pop_front();
          if (resp_rdata[k] !== exp || resp_err[k] !== 1'b0) begin
            n_err++;
            $display("FAIL b2b_data k=%0d n=%0d rdata=%h want %h err=%b", k, got, resp_rdata[k], exp, resp_err[k]);
          end
        end
        got++;
        @(negedge clk);
      end else if (req_valid[k] === 1'b1 && req_ready[k] === 1'b1) begin
        if (last_acc >= 0) begin
          n_cmp++;
          if (cyc - last_acc !== lat_of(k) + 1) begin
            n_err++;
            $display("FAIL b2b_rate k=%0d interval=%0d want %0d", k, cyc - last_acc, lat_of(k) + 1);
          end
        end
        last_acc = cyc;
        exp_q.push_back(mdl_mem[k][int'((req_addr[k] - BASE) / 8)]);
        issued++;
        @(posedge clk); #1;
        req_addr[k] = RB + 64'(8 * issued);
        if (issued == 6) req_valid[k] = 1'b0;
        @(negedge clk);
      end else begin
        @(negedge clk);
      end
    end
    n_cmp++;
    if (got !== 6) begin
      n_err++;
      $display("FAIL b2b_count k=%0d responses=%0d want 6", k, got);
    end
    req_valid[k]  = 1'b0;
    resp_ready[k] = 1'b0;
  endtask

  task automatic test_reset_mid_op(input int k);
    logic [63:0] old_v, new_v;
    old_v = {$urandom, $urandom};
    new_v = {$urandom, $urandom};
    model_apply(k, 1'b1, 64'h8000_0008, old_v, 8'hFF);
    do_txn(k, 1'b1, 64'h8000_0008, old_v, 8'hFF, 0);
    // reset one cycle after acceptance, while waiting
    @(negedge clk);
    req_valid[k] = 1'b1; req_wen[k] = 1'b1; req_addr[k] = 64'h8000_0008;
    req_wdata[k] = 64'hAA; req_wmask[k] = 8'hFF;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    @(negedge clk);
    rst[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (req_ready[k] !== 1'b0 || resp_valid[k] !== 1'b0 || resp_rdata[k] !== 64'd0 || resp_err[k] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_wait_outputs k=%0d req_ready=%b resp_valid=%b rdata=%h err=%b want all 0",
               k, req_ready[k], resp_valid[k], resp_rdata[k], resp_err[k]);
    end
    rst[k] = 1'b0;
    model_apply(k, 1'b0, 64'h8000_0008, 64'd0, 8'h00);
    do_txn(k, 1'b0, 64'h8000_0008, 64'd0, 8'h00, 0);
    n_cmp++;
    if (o_rdata !== old_v || o_err !== 1'b0 || o_lat !== lat_of(k)) begin
      n_err++;
      $display("FAIL rst_wait_dropped k=%0d rdata=%h want %h err=%b lat=%0d", k, o_rdata, old_v, o_err, o_lat);
    end
    // reset while the write response is pending: the write stays committed
    @(negedge clk);
    req_valid[k] = 1'b1; req_wen[k] = 1'b1; req_addr[k] = 64'h8000_0008;
    req_wdata[k] = new_v; req_wmask[k] = 8'hFF;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    for (int c = 0; c < 40 && resp_valid[k] !== 1'b1; c++) @(negedge clk);
    n_cmp++;
    if (resp_valid[k] !== 1'b1) begin
      n_err++;
      $display("FAIL rst_resp_reach k=%0d resp_valid=%b want 1", k, resp_valid[k]);
    end
    rst[k] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (resp_valid[k] !== 1'b0 || resp_rdata[k] !== 64'd0 || resp_err[k] !== 1'b0) begin
      n_err++;
      $display("FAIL rst_resp_outputs k=%0d resp_valid=%b rdata=%h err=%b want 0", k, resp_valid[k], resp_rdata[k], resp_err[k]);
    end
    rst[k] = 1'b0;
    model_apply(k, 1'b1, 64'h8000_0008, new_v, 8'hFF);
    model_apply(k, 1'b0, 64'h8000_0008, 64'd0, 8'h00);
    do_txn(k, 1'b0, 64'h8000_0008, 64'd0, 8'h00, 0);
    n_cmp++;
    if (o_rdata !== e_rdata || o_err !== 1'b0) begin
      n_err++;
      $display("FAIL rst_resp_committed k=%0d rdata=%h want %h err=%b", k, o_rdata, e_rdata, o_err);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    for (int k = 0; k < NI; k++) begin
      rst[k] = 1'b1; req_valid[k] = 1'b0; req_wen[k] = 1'b0; req_addr[k] = 64'd0;
      req_wdata[k] = 64'd0; req_wmask[k] = 8'd0; resp_ready[k] = 1'b0;
    end
    test_reset();
    for (int k = 0; k < NI; k++) begin
      test_write_read(k);
      test_byte_mask(k);
      test_out_of_range(k);
      test_backpressure(k);
      test_random(k);
      test_back_to_back(k);
    end
    test_reset_mid_op(1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22050612_dmem_responder.md
# ysyx_22050612_dmem_responder

Data-memory responder for the ysyx_22050612 core: the target end of the load/store interface that the EXU drives as initiator. It accepts one 64-bit read or byte-masked write request at a time over a valid/ready handshake. It services the request from an internal doubleword-organised SRAM after a fixed, parameterised latency, and returns data or write completion over a second valid/ready handshake. It replaces the DPI pmem_read/pmem_write path for synthesizable memory.

## Interface
- DEPTH_LOG2, 10: log2 of the number of 64-bit words; 1024 words is 8 KiB.
- BASE, 64'h8000_0000: byte address of word 0.
- LATENCY, 2: cycles from request acceptance to resp_valid; legal range 1..15.

- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_wen  in  1  1 = write, 0 = read.
- req_addr  in  64  byte address; bits [2:0] are ignored, giving doubleword-aligned access.
- req_wdata  in  64  write data.
- req_wmask  in  8  byte enables; bit i enables req_wdata[8i+7:8i].
- resp_valid  out  1  response present.
- resp_ready  in  1  initiator accepts the response.
- resp_rdata  out  64  read data; 0 for writes and for errors.
- resp_err  out  1  address was out of range.

## Operation
- FSM states are IDLE, WAIT and RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid && req_ready, latch wen, addr, wdata and wmask.
  - Load the counter with LATENCY-1.
  - Go to WAIT, or go directly to RESP if LATENCY == 1.
- WAIT:
  - req_ready = 0.
  - The counter decrements each cycle.
  - When the counter is 1 at a clock edge, go to RESP on that edge.
- Memory access happens on the edge that enters RESP:
  - Read: capture mem[idx] into resp_rdata.
  - Write: bytes with mask=1 are written; bytes with mask=0 keep their value. resp_rdata is 0.
- Address decode:
  - idx = (addr - BASE) >> 3, truncated to DEPTH_LOG2 bits.
  - In range when BASE <= addr < BASE + 8·2^DEPTH_LOG2; the 64-bit compare must not wrap.
  - Out of range: resp_err = 1, resp_rdata = 0, memory unchanged.
- Write with wmask = 0: no memory change, resp_err = 0.
- RESP:
  - resp_valid = 1 and req_ready = 0.
  - resp_rdata and resp_err are held stable until resp_valid && resp_ready.
  - On that handshake go to IDLE. resp_valid is 0 in the following cycle.
- Only one transaction is outstanding at a time. No request is accepted in the cycle of the response handshake.

## Timing
- Reset, while rst = 1 and on the first cycle after:
  - FSM state is IDLE.
  - req_ready = 0 during rst and 1 in the first cycle after rst falls.
  - resp_valid = 0, resp_rdata = 0, resp_err = 0.
  - Memory contents are not reset.
- Latency: request accepted at edge T means resp_valid = 1 in the cycle following edge T+LATENCY-1, i.e. LATENCY cycles later.
- Peak throughput is one transaction per LATENCY+1 cycles, with resp_ready tied high.
- req_ready and resp_valid are decoded from registered state only; there is no combinational path from req_valid or resp_ready to any output.
- Request inputs are sampled only at the acceptance edge. Changes to them afterwards have no effect.
- Backpressure: resp_ready = 0 holds RESP indefinitely with outputs unchanged. A write is committed exactly once regardless of stall length.
- Reset mid-operation:
  - rst in WAIT drops the transaction; no write is performed.
  - rst in RESP drops the response; a write already committed stays committed.
- rst has priority over every handshake in the same cycle.

## Test plan
- Write/read: write addr 0x8000_0010, wdata 0x1122_3344_5566_7788, wmask 0xFF, then read 0x8000_0010 -> resp_rdata = 0x1122_3344_5566_7788, resp_err = 0, resp_valid exactly LATENCY cycles after each acceptance.
- Byte mask: preload 0xFFFF_FFFF_FFFF_FFFF at 0x8000_0020, write 0 with wmask 0x0F, read 0x8000_0027 -> 0xFFFF_FFFF_0000_0000 (low address bits ignored).
- Out of range: read 0x7FFF_FFF8 and write 0x8000_2000 (DEPTH_LOG2 = 10) -> resp_err = 1, resp_rdata = 0; subsequent read of word 0 is unchanged.
- Backpressure: hold resp_ready = 0 for 5 cycles in RESP -> resp_valid and resp_rdata stable, req_ready = 0 throughout, a 2nd req_valid is not accepted; after the handshake, resp_valid drops and req_ready = 1 next cycle.
- Reset mid-op: write 0xAA to 0x8000_0008 (LATENCY = 3), assert rst one cycle after acceptance -> all outputs 0, and a later read of 0x8000_0008 returns the old value.
- Latency sweep: LATENCY = 1 and 15 with resp_ready tied high -> back-to-back reads complete one per LATENCY+1 cycles with correct data.
